// File: rtl/mem_access_sequencer.sv
// Splits 32-bit word / 8-bit byte loads and stores into single-byte data-memory accesses (little-endian).
// Optional build macro MEM_SEQ_SIGN_EXT_EN enables sign extension of byte loads.
module mem_access_sequencer #(
    parameter int N    = 16,
    parameter int BITS = 32,
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic            req_word,
    input  logic            req_signed,
    input  logic [N-3:0]    req_idx,
    input  logic [BITS-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_we,
    output logic [N-1:0]    mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    output logic            resp_valid,
    output logic            resp_we,
    output logic [BITS-1:0] resp_data,
    output logic [RD_W-1:0] resp_rd
);
    localparam int IDX_W = N - 2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state;
    logic            we_q;
    logic            word_q;
    logic [IDX_W-1:0] idx_q;
    logic [BITS-1:0] wdata_q;
    logic [BITS-1:0] buf_q;
    logic [RD_W-1:0] rd_q;
    logic [1:0]      cnt;
    logic [1:0]      cnt_nxt;
    logic            last;
    logic [BITS-1:0] load_result;

`ifdef MEM_SEQ_SIGN_EXT_EN
    logic            signed_q;
`else
    logic            unused_signed;
    assign unused_signed = req_signed;
`endif

    // Memory entries are one byte wide; the upper read lanes carry nothing.
    logic            unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[BITS-1:8];

    assign req_ready = (state == IDLE);

    always_comb begin
        cnt_nxt = cnt + 2'd1;
        last    = word_q ? (cnt == 2'd3) : (cnt == 2'd0);
    end

    always_comb begin
        load_result = {{(BITS-8){1'b0}}, buf_q[7:0]};
        if (we_q)
            load_result = '0;
        else if (word_q)
            load_result = buf_q;
`ifdef MEM_SEQ_SIGN_EXT_EN
        else if (signed_q)
            load_result = {{(BITS-8){buf_q[7]}}, buf_q[7:0]};
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            word_q     <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            rd_q       <= '0;
            cnt        <= 2'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
`ifdef MEM_SEQ_SIGN_EXT_EN
            signed_q   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        word_q    <= req_word;
                        idx_q     <= req_idx;
                        wdata_q   <= req_wdata;
                        rd_q      <= req_rd;
                        buf_q     <= '0;
                        cnt       <= 2'd0;
`ifdef MEM_SEQ_SIGN_EXT_EN
                        signed_q  <= req_signed;
`endif
                        // Memory drive is registered, so the first byte is presented right away.
                        mem_we    <= req_we;
                        mem_addr  <= {req_idx, 2'b00};
                        mem_wdata <= {{(BITS-8){1'b0}}, req_wdata[7:0]};
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        buf_q[8*cnt +: 8] <= mem_rdata[7:0];
                    if (last) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= DONE;
                    end else begin
                        cnt       <= cnt_nxt;
                        mem_addr  <= {idx_q + IDX_W'(cnt_nxt), 2'b00};
                        mem_wdata <= {{(BITS-8){1'b0}}, wdata_q[8*cnt_nxt +: 8]};
                    end
                end
                DONE: begin
                    resp_valid <= 1'b1;
                    resp_we    <= we_q;
                    resp_data  <= load_result;
                    resp_rd    <= rd_q;
                    cnt        <= 2'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits between the execute/memory pipeline register and the byte-wide data memory, and drives that memory's write_enable, address and write_data ports.
- Converts 32-bit word and 8-bit byte load/store requests into sequences of single-byte memory accesses. Bytes are little-endian.
- Assembles load results and presents a registered response to the writeback stage.
- Stalls upstream through a ready handshake while a sequence is in flight.

Parameters:
- N, 16, data memory address width. Byte index width is N-2.
- BITS, 32, data word width. Fixed at 32; the byte count per word is 4.
- RD_W, 4, destination register tag width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present; held stable by upstream until accepted.
- req_ready  output  1  sequencer idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_word  input  1  1 = 32-bit access, 0 = byte access.
- req_signed  input  1  sign-extend byte loads. Used only when SIGN_EXT_EN is defined.
- req_idx  input  N-2  byte index (memory entry number).
- req_wdata  input  BITS  store data.
- req_rd  input  RD_W  destination register tag.
- mem_we  output  1  to data memory write_enable.
- mem_addr  output  N  to data memory address; always {byte_index, 2'b00}.
- mem_wdata  output  BITS  to data memory write_data; {24'b0, current byte}.
- mem_rdata  input  BITS  from data memory read_data. Combinational read; only [7:0] is used.
- resp_valid  output  1  one-cycle pulse when a request completes.
- resp_we  output  1  echo of the latched req_we.
- resp_data  output  BITS  load result. 0 for stores.
- resp_rd  output  RD_W  echo of the latched req_rd.

Behaviour:
- States: IDLE, ACCESS, DONE.

IDLE:
- req_ready = 1.
- When req_valid = 1: latch we, word, signed, idx, wdata and rd; clear the data buffer; set cnt = 0; go to ACCESS.

ACCESS:
- Memory drive:
  - mem_addr = {(idx + cnt) mod 2^(N-2), 2'b00}.
  - mem_we = latched we.
  - mem_wdata = {24'b0, wdata[8*cnt+7 : 8*cnt]}.
- Loads capture mem_rdata[7:0] into buffer byte cnt at the clock edge.
- Last byte is cnt = 3 for a word access and cnt = 0 for a byte access.
- At the last byte go to DONE; otherwise increment cnt.

DONE:
- resp_valid = 1 for exactly one cycle, then go to IDLE.
- resp_data:
  - word load: assembled buffer.
  - byte load: zero-extended byte.
  - store: 0.

Outside ACCESS:
- mem_we = 0, mem_addr = 0, mem_wdata = 0.

Response outputs:
- resp_we, resp_data and resp_rd are registered.
- They hold their value until the next DONE; only resp_valid pulses.

Handshake and timing:
- req_ready is high only in IDLE. There is no acceptance in DONE, so there are no back-to-back transfers.
- Latency from the acceptance edge to resp_valid high: 2 cycles for a byte, 5 cycles for a word.
- Occupancy, including the IDLE accept cycle: 3 cycles for a byte, 6 cycles for a word.
- A request is accepted only in the cycle where req_valid and req_ready are both 1. Changes to req_* while not ready are ignored.

Boundary conditions:
- Index wrap: idx + cnt wraps modulo 2^(N-2). For example, a word at 0x3FFE with N = 16 touches 0x3FFE, 0x3FFF, 0x0000 and 0x0001.
- No alignment restriction on word accesses.

Reset:
- Asynchronous, active-low; takes effect immediately, including mid-sequence.
- Reset state: IDLE, cnt = 0, buffer = 0, req_ready = 1, resp_valid = 0, resp_we = 0, resp_data = 0, resp_rd = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Bytes already written by an aborted store remain in memory; no rollback.

Optional Feature:
- Macro: MEM_SEQ_SIGN_EXT_EN.
- Defined: for a byte load with latched signed = 1, resp_data = {{24{byte[7]}}, byte}. Word loads and stores are unaffected.
- Undefined: req_signed is ignored and byte loads are always zero-extended. The signed bit is not latched, and no sign logic is synthesized.

Test Plan:
- Reset mid-store:
  - Stimulus: rst_n low for 2 cycles, then high; issue a word store, and assert rst_n low during its second ACCESS cycle.
  - Required: all outputs are 0 and req_ready = 1 immediately. Byte 0x0010 is already written; 0x0011 is not.
- Word store:
  - Stimulus: idx 0x0010, wdata 0xDEADBEEF.
  - Required: four cycles with mem_we = 1 and, in order, mem_addr = 0x0040/0x0044/0x0048/0x004C and mem_wdata = 0xEF/0xBE/0xAD/0xDE. resp_valid pulses 5 cycles after acceptance, with resp_data = 0.
- Word load:
  - Stimulus: word load of idx 0x0010 after the word store, with rd 5.
  - Required: resp_data = 0xDEADBEEF and resp_rd = 5; req_ready is low for 5 cycles.
- Byte load with memory byte 0x80:
  - Stimulus: byte load, req_signed = 1.
  - Required: resp_data = 0x00000080 without MEM_SEQ_SIGN_EXT_EN; 0xFFFFFF80 with it. Latency is 2 cycles.
- Word store with index wrap:
  - Stimulus: idx 0x3FFE, wdata 0x11223344.
  - Required: mem_addr sequence 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Back-to-back requests:
  - Stimulus: req_valid held high across two queued requests.
  - Required: the second request is accepted only in the IDLE cycle after resp_valid. Request fields changed while req_ready = 0 do not affect the in-flight response.
